// File: rtl/ser_pkg.sv
// ----------------------------------------------------------------------------
// ser_pkg: definitions shared by the RISC5 serial transmitter and receiver.
//   state_t              receiver FSM state encoding
//   CLKS_PER_BIT_DEFAULT default bit time in clocks (same rate as transmitter)
//   DATA_BITS            data bits per 8N1 frame
// ----------------------------------------------------------------------------
package ser_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    localparam int CLKS_PER_BIT_DEFAULT = 12;
    localparam int DATA_BITS            = 8;

endpackage : ser_pkg

// File: rtl/bit_sync.sv
// ----------------------------------------------------------------------------
// bit_sync: two-flop synchronizer for a single asynchronous input.
//   clk  in   destination clock
//   rst  in   asynchronous active-low reset; both flops reset to 1 (idle line)
//   d    in   asynchronous input
//   q    out  synchronized output (two clocks of latency)
// ----------------------------------------------------------------------------
module bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : bit_sync

// File: rtl/rcvr.sv
// ----------------------------------------------------------------------------
// rcvr: 8N1 asynchronous serial receiver for the RISC5 I/O subsystem.
//   clk   in   system clock, all state on rising edge
//   rst   in   asynchronous active-low reset
//   rxd   in   serial line, idle high, asynchronous to clk
//   read  in   one-cycle strobe: CPU has consumed data
//   data  out  last received byte (never cleared by read)
//   rdy   out  data holds an unread byte
//   ferr  out  sticky framing error
//   ovr   out  sticky overrun error
//
// Handshake: rdy rises on the clock edge that samples a good stop bit. A
// read strobe clears rdy, ferr and ovr on the next edge. If a byte completes
// in the same cycle as read, the new byte wins (rdy stays 1, ovr stays
// cleared); a byte completing while rdy=1 without read overwrites data and
// sets ovr. A framing error in the same cycle as read still sets ferr.
//
// CLKS_PER_BIT must be even and >= 4.
// ----------------------------------------------------------------------------
module rcvr
    import ser_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       read,
    output logic [7:0] data,
    output logic       rdy,
    output logic       ferr,
    output logic       ovr
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);

    logic          rxd_s;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bitidx;
    logic [7:0]    shift;

    bit_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            bitidx <= '0;
            shift  <= '0;
            data   <= 8'h00;
            rdy    <= 1'b0;
            ferr   <= 1'b0;
            ovr    <= 1'b0;
        end else begin
            // Read clears first; frame-completion assignments below override.
            if (read) begin
                rdy  <= 1'b0;
                ferr <= 1'b0;
                ovr  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state <= START;
                        cnt   <= CW'(HALF_BIT - 1);
                    end
                end

                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!rxd_s) begin
                        // Start bit still low at mid-bit: a real frame.
                        state  <= DATA;
                        cnt    <= CW'(CLKS_PER_BIT - 1);
                        bitidx <= '0;
                    end else begin
                        // Glitch shorter than half a bit: drop silently.
                        state <= IDLE;
                    end
                end

                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shift <= {rxd_s, shift[7:1]};
                        cnt   <= CW'(CLKS_PER_BIT - 1);
                        if (bitidx == 3'(DATA_BITS - 1)) begin
                            state <= STOP;
                        end else begin
                            bitidx <= bitidx + 1'b1;
                        end
                    end
                end

                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (rxd_s) begin
                        data  <= shift;
                        rdy   <= 1'b1;
                        // Overrun only if the previous byte is still unread
                        // after this cycle's read.
                        if (rdy && !read) begin
                            ovr <= 1'b1;
                        end
                        state <= IDLE;
                    end else begin
                        ferr  <= 1'b1;
                        state <= BREAK;
                    end
                end

                BREAK: begin
                    // Line held low: wait for it to return high so a break
                    // reports only one framing error.
                    if (rxd_s) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule : rcvr

// File: tb/tb_rcvr.sv
module tb_rcvr;
    import ser_pkg::*;

    localparam int CPB = 12;

    // ---------------- clock / reset ----------------
    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       rxd  = 1'b1;
    logic       read = 1'b0;
    logic [7:0] data;
    logic       rdy;
    logic       ferr;
    logic       ovr;

    always #5 clk = ~clk;

    rcvr #(.CLKS_PER_BIT(CPB)) dut (
        .clk  (clk),
        .rst  (rst),
        .rxd  (rxd),
        .read (read),
        .data (data),
        .rdy  (rdy),
        .ferr (ferr),
        .ovr  (ovr)
    );

    // ---------------- scoreboard ----------------
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks (called and return at a negedge) --------
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic pulse_read();
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] tx;
        logic       do_read;
        logic [7:0] exp_data;
        logic       exp_rdy;
        logic       exp_ferr;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[5];
    int   lat;

    initial begin
        vecs[0] = '{tx: 8'hA3, do_read: 1'b1, exp_data: 8'hA3, exp_rdy: 1'b1, exp_ferr: 1'b0, exp_ovr: 1'b0};
        vecs[1] = '{tx: 8'h00, do_read: 1'b1, exp_data: 8'h00, exp_rdy: 1'b1, exp_ferr: 1'b0, exp_ovr: 1'b0};
        vecs[2] = '{tx: 8'hFF, do_read: 1'b1, exp_data: 8'hFF, exp_rdy: 1'b1, exp_ferr: 1'b0, exp_ovr: 1'b0};
        vecs[3] = '{tx: 8'h11, do_read: 1'b0, exp_data: 8'h11, exp_rdy: 1'b1, exp_ferr: 1'b0, exp_ovr: 1'b0};
        vecs[4] = '{tx: 8'h22, do_read: 1'b1, exp_data: 8'h22, exp_rdy: 1'b1, exp_ferr: 1'b0, exp_ovr: 1'b1};

        // Reset held while the line toggles.
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            rxd = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check("rst_data", data, 8'h00);
        check("rst_rdy", rdy, 1'b0);
        check("rst_ferr", ferr, 1'b0);
        check("rst_ovr", ovr, 1'b0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        rxd = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (200) @(negedge clk);
        check("idle_rdy", rdy, 1'b0);
        check("idle_ferr", ferr, 1'b0);

        // First byte with latency measurement.
        fork
            send_frame(8'h55, 1'b1);
            begin
                lat = 0;
                while (!rdy && lat < 200) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
            end
        join
        checks++;
        if (lat < 115 || lat > 117) begin
            failures++;
            $display("FAIL latency: got %0d cycles expected 115..117", lat);
        end
        check("b55_data", data, 8'h55);
        check("b55_rdy", rdy, 1'b1);
        pulse_read();
        check("b55_rdy_after_read", rdy, 1'b0);

        // Back-to-back bytes and overrun from the table.
        foreach (vecs[i]) begin
            send_frame(vecs[i].tx, 1'b1);
            exp_q.push_back(vecs[i].exp_data);
            check($sformatf("vec%0d_data", i), data, exp_q.pop_front());
            check($sformatf("vec%0d_rdy", i), rdy, vecs[i].exp_rdy);
            check($sformatf("vec%0d_ferr", i), ferr, vecs[i].exp_ferr);
            check($sformatf("vec%0d_ovr", i), ovr, vecs[i].exp_ovr);
            if (vecs[i].do_read) begin
                pulse_read();
                check($sformatf("vec%0d_rd_rdy", i), rdy, 1'b0);
                check($sformatf("vec%0d_rd_ovr", i), ovr, 1'b0);
                check($sformatf("vec%0d_rd_ferr", i), ferr, 1'b0);
            end
        end

        // Start-bit glitch: three low cycles only.
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_rdy", rdy, 1'b0);
        check("glitch_ferr", ferr, 1'b0);
        check("glitch_state", 32'(dut.state), 32'(IDLE));
        send_frame(8'h41, 1'b1);
        check("b41_data", data, 8'h41);
        check("b41_rdy", rdy, 1'b1);
        pulse_read();

        // Framing error followed by a held-low line.
        send_frame(8'h7E, 1'b0);
        repeat (50) @(negedge clk);
        check("frm_ferr", ferr, 1'b1);
        check("frm_rdy", rdy, 1'b0);
        check("frm_data", data, 8'h41);
        rxd = 1'b1;
        repeat (10) @(negedge clk);
        check("frm_state_idle", 32'(dut.state), 32'(IDLE));
        send_frame(8'h12, 1'b1);
        check("b12_data", data, 8'h12);
        check("b12_rdy", rdy, 1'b1);
        check("b12_ferr_sticky", ferr, 1'b1);
        pulse_read();
        check("b12_ferr_cleared", ferr, 1'b0);
        check("b12_rdy_cleared", rdy, 1'b0);

        // Read on the exact completion edge of 0x33 while 0x11 is pending.
        send_frame(8'h11, 1'b1);
        check("pend_rdy", rdy, 1'b1);
        fork
            send_frame(8'h33, 1'b1);
            begin
                repeat (116) @(negedge clk);
                read = 1'b1;
                @(negedge clk);
                read = 1'b0;
            end
        join
        check("coll_data", data, 8'h33);
        check("coll_rdy", rdy, 1'b1);
        check("coll_ovr", ovr, 1'b0);
        pulse_read();

        // Reset in the middle of the data bits.
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
        rxd = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_data", data, 8'h00);
        check("midrst_state", 32'(dut.state), 32'(IDLE));
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (200) @(negedge clk);
        check("midrst_rdy", rdy, 1'b0);
        check("midrst_ferr", ferr, 1'b0);
        send_frame(8'h5A, 1'b1);
        check("b5a_data", data, 8'h5A);
        check("b5a_rdy", rdy, 1'b1);
        check("b5a_ovr", ovr, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rcvr
